pipe_scoreboard: RTL

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_scoreboard.sv
// Register-writeback scoreboard: tracks one pending-latency counter per register
// and decides issue stalls, operand forwarding and the single writeback slot.
module pipe_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned MAX_LAT = 8,
    localparam int unsigned IDX_W  = $clog2(NREG),
    localparam int unsigned CNT_W  = $clog2(MAX_LAT + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_rs1,
    input  logic [IDX_W-1:0] issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic             issue_we,
    input  logic [IDX_W-1:0] issue_rd,
    input  logic [CNT_W-1:0] issue_lat,
    input  logic             flush,
    input  logic             hold,
    output logic             issue_stall,
    output logic             issue_accept,
    output logic             fwd_rs1,
    output logic             fwd_rs2,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_rd,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic [CNT_W-1:0] lat_eff;
    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;
    logic [CNT_W-1:0] cnt_rd;
    logic             writes_reg;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             haz_waw;
    logic             haz_port;
    logic             any_done;
    logic [IDX_W-1:0] done_rd;
    logic             any_pend;

    // Clamp the requested latency into 1..MAX_LAT.
    always_comb begin
        lat_eff = issue_lat;
        if (issue_lat == '0) begin
            lat_eff = CNT_ONE;
        end else if (issue_lat > CNT_MAX) begin
            lat_eff = CNT_MAX;
        end
    end

    assign cnt_rs1    = cnt_q[issue_rs1];
    assign cnt_rs2    = cnt_q[issue_rs2];
    assign cnt_rd     = cnt_q[issue_rd];
    assign writes_reg = issue_we & (issue_rd != '0);

    assign haz_rs1 = issue_use_rs1 & (issue_rs1 != '0) & (cnt_rs1 > CNT_ONE);
    assign haz_rs2 = issue_use_rs2 & (issue_rs2 != '0) & (cnt_rs2 > CNT_ONE);
    assign haz_waw = writes_reg & (cnt_rd > CNT_ONE);

    // Scan all counters: writeback-slot collision, completing register, occupancy.
    always_comb begin
        haz_port = 1'b0;
        any_done = 1'b0;
        done_rd  = '0;
        any_pend = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (cnt_q[r] == lat_eff + CNT_ONE) begin
                haz_port = writes_reg;
            end
            if (cnt_q[r] == CNT_ONE) begin
                any_done = 1'b1;
                done_rd  = done_rd | IDX_W'(r);
            end
            if (cnt_q[r] != '0) begin
                any_pend = 1'b1;
            end
        end
    end

    assign issue_stall  = issue_valid & (hold | haz_rs1 | haz_rs2 | haz_waw | haz_port);
    assign issue_accept = issue_valid & ~issue_stall & ~flush;

    assign fwd_rs1 = issue_valid & issue_use_rs1 & (issue_rs1 != '0) & (cnt_rs1 == CNT_ONE) & ~hold;
    assign fwd_rs2 = issue_valid & issue_use_rs2 & (issue_rs2 != '0) & (cnt_rs2 == CNT_ONE) & ~hold;

    assign wb_valid = ~hold & any_done;
    assign wb_rd    = wb_valid ? done_rd : '0;
    assign busy     = any_pend;

    // Countdown unless frozen; a fresh issue reloads its destination.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!hold && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
            if (issue_accept && writes_reg && issue_rd == IDX_W'(r)) begin
                cnt_d[r] = lat_eff;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule
